// File: rtl/max7219_spi_receiver.sv
// MAX7219-compatible SPI slave: synchronizes the SPI pins into the clk domain,
// shifts 16-bit frames MSB first and writes the addressed display register
// when chip select closes the frame.
module max7219_spi_receiver #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sclk,
   input  logic       mosi,
   input  logic       cs,
   output logic       dout,
   input  logic [2:0] rd_addr,
   output logic [7:0] rd_data,
   output logic       shutdown_n,
   output logic [7:0] decode_mode,
   output logic [3:0] intensity,
   output logic [2:0] scan_limit,
   output logic       display_test,
   output logic       frame_valid,
   output logic       frame_err,
   output logic [3:0] frame_addr,
   output logic [7:0] frame_data
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
   logic                   sclk_prev_q, sclk_prev_d;
   logic                   cs_prev_q,   cs_prev_d;

   logic [15:0]      shift_reg_q, shift_reg_d;
   logic [4:0]       bit_cnt_q,   bit_cnt_d;
   logic             dout_q,      dout_d;
   logic [7:0][7:0]  row_q,       row_d;
   logic             shutdown_n_q,   shutdown_n_d;
   logic [7:0]       decode_mode_q,  decode_mode_d;
   logic [3:0]       intensity_q,    intensity_d;
   logic [2:0]       scan_limit_q,   scan_limit_d;
   logic             display_test_q, display_test_d;
   logic             frame_valid_q,  frame_valid_d;
   logic             frame_err_q,    frame_err_d;
   logic [3:0]       frame_addr_q,   frame_addr_d;
   logic [7:0]       frame_data_q,   frame_data_d;

   logic sclk_s, mosi_s, cs_s;
   logic sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic [2:0] row_idx;

   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
   assign cs_s   = cs_sync_q[SYNC_STAGES-1];

   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign cs_rise   = cs_s & ~cs_prev_q;
   assign cs_fall   = ~cs_s & cs_prev_q;

   // Addresses 1..8 map to rows 0..7; the low three bits minus one wrap 8 to 7.
   assign row_idx = shift_reg_q[10:8] - 3'd1;

   // Synchronizer shift and edge-detect history.
   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
      sclk_prev_d = sclk_s;
      cs_prev_d   = cs_s;
   end

   // Frame FSM: next state, shifting, and register writes on frame close.
   always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_d        = state_q;
      shift_reg_d    = shift_reg_q;
      bit_cnt_d      = bit_cnt_q;
      dout_d         = dout_q;
      row_d          = row_q;
      shutdown_n_d   = shutdown_n_q;
      decode_mode_d  = decode_mode_q;
      intensity_d    = intensity_q;
      scan_limit_d   = scan_limit_q;
      display_test_d = display_test_q;
      frame_valid_d  = 1'b0;
      frame_err_d    = 1'b0;
      frame_addr_d   = frame_addr_q;
      frame_data_d   = frame_data_q;

      case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d   = SHIFT;
               bit_cnt_d = '0;
            end
         end
         SHIFT: begin
            // A cs rising edge wins over any sclk edge seen in the same clk.
            if (cs_rise) begin
               state_d = LATCH;
            end else begin
               if (sclk_rise) begin
                  shift_reg_d = {shift_reg_q[14:0], mosi_s};
                  if (bit_cnt_q != 5'd31) bit_cnt_d = bit_cnt_q + 5'd1;
               end
               if (sclk_fall) dout_d = shift_reg_q[15];
            end
         end
         LATCH: begin
            state_d = IDLE;
            if (bit_cnt_q >= 5'd16) begin
               frame_valid_d = 1'b1;
               frame_addr_d  = shift_reg_q[11:8];
               frame_data_d  = shift_reg_q[7:0];
               case (shift_reg_q[11:8])
                  4'h1, 4'h2, 4'h3, 4'h4,
                  4'h5, 4'h6, 4'h7, 4'h8: row_d[row_idx] = shift_reg_q[7:0];
                  4'h9:    decode_mode_d  = shift_reg_q[7:0];
                  4'hA:    intensity_d    = shift_reg_q[3:0];
                  4'hB:    scan_limit_d   = shift_reg_q[2:0];
                  4'hC:    shutdown_n_d   = shift_reg_q[0];
                  4'hF:    display_test_d = shift_reg_q[0];
                  default: ; // 0x0 no-op, 0xD/0xE ignored
               endcase
            end else begin
               frame_err_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sclk_sync_q    <= '0;
         mosi_sync_q    <= '0;
         // cs history resets low so a cs already low at release makes no
         // falling edge; the frame only opens after cs goes high then low.
         cs_sync_q      <= '0;
         sclk_prev_q    <= 1'b0;
         cs_prev_q      <= 1'b0;
         state_q        <= IDLE;
         shift_reg_q    <= '0;
         bit_cnt_q      <= '0;
         dout_q         <= 1'b0;
         // NOTE: the row array is a visible register file, so it is reset like
         // any other output; a plain storage RAM would normally be left unreset.
         row_q          <= '0;
         shutdown_n_q   <= 1'b0;
         decode_mode_q  <= '0;
         intensity_q    <= '0;
         scan_limit_q   <= '0;
         display_test_q <= 1'b0;
         frame_valid_q  <= 1'b0;
         frame_err_q    <= 1'b0;
         frame_addr_q   <= '0;
         frame_data_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         sclk_sync_q    <= sclk_sync_d;
         mosi_sync_q    <= mosi_sync_d;
         cs_sync_q      <= cs_sync_d;
         sclk_prev_q    <= sclk_prev_d;
         cs_prev_q      <= cs_prev_d;
         state_q        <= state_d;
         shift_reg_q    <= shift_reg_d;
         bit_cnt_q      <= bit_cnt_d;
         dout_q         <= dout_d;
         row_q          <= row_d;
         shutdown_n_q   <= shutdown_n_d;
         decode_mode_q  <= decode_mode_d;
         intensity_q    <= intensity_d;
         scan_limit_q   <= scan_limit_d;
         display_test_q <= display_test_d;
         frame_valid_q  <= frame_valid_d;
         frame_err_q    <= frame_err_d;
         frame_addr_q   <= frame_addr_d;
         frame_data_q   <= frame_data_d;
      end
   end

   assign dout         = dout_q;
   assign rd_data      = row_q[rd_addr];
   assign shutdown_n   = shutdown_n_q;
   assign decode_mode  = decode_mode_q;
   assign intensity    = intensity_q;
   assign scan_limit   = scan_limit_q;
   assign display_test = display_test_q;
   assign frame_valid  = frame_valid_q;
   assign frame_err    = frame_err_q;
   assign frame_addr   = frame_addr_q;
   assign frame_data   = frame_data_q;

endmodule

// File: tb/tb_max7219_spi_receiver.sv
// Bench for max7219_spi_receiver: an SPI master drives frames, a scoreboard
// queue holds the expected frame events and a register model holds the
// expected display state.
module tb_max7219_spi_receiver;

   localparam int HALF = 6; // clk cycles per SPI phase, above SYNC_STAGES+2

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sclk = 1'b0;
   logic       mosi = 1'b0;
   logic       cs = 1'b1;
   logic       dout;
   logic [2:0] rd_addr = '0;
   logic [7:0] rd_data;
   logic       shutdown_n;
   logic [7:0] decode_mode;
   logic [3:0] intensity;
   logic [2:0] scan_limit;
   logic       display_test;
   logic       frame_valid;
   logic       frame_err;
   logic [3:0] frame_addr;
   logic [7:0] frame_data;

   max7219_spi_receiver #(.SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .cs(cs),
      .dout(dout), .rd_addr(rd_addr), .rd_data(rd_data),
      .shutdown_n(shutdown_n), .decode_mode(decode_mode),
      .intensity(intensity), .scan_limit(scan_limit),
      .display_test(display_test), .frame_valid(frame_valid),
      .frame_err(frame_err), .frame_addr(frame_addr), .frame_data(frame_data)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       err;
      logic [3:0] addr;
      logic [7:0] data;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  failures = 0;

   // Register model.
   logic [7:0] exp_row [8];
   logic       exp_shdn;
   logic [7:0] exp_decode;
   logic [3:0] exp_int;
   logic [2:0] exp_scan;
   logic       exp_test;
   logic [31:0] dout_cap;

   function automatic void model_reset();
      for (int i = 0; i < 8; i++) exp_row[i] = 8'h00;
      exp_shdn = 1'b0; exp_decode = 8'h00; exp_int = 4'h0;
      exp_scan = 3'h0; exp_test = 1'b0;
   endfunction

   function automatic void model_write(input logic [3:0] a, input logic [7:0] d);
      case (a)
         4'h1, 4'h2, 4'h3, 4'h4,
         4'h5, 4'h6, 4'h7, 4'h8: exp_row[int'(a) - 1] = d;
         4'h9: exp_decode = d;
         4'hA: exp_int    = d[3:0];
         4'hB: exp_scan   = d[2:0];
         4'hC: exp_shdn   = d[0];
         4'hF: exp_test   = d[0];
         default: ;
      endcase
   endfunction

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive nbits of word MSB first; dout is captured after each falling edge.
   // When expect_ev is set the frame outcome is queued and the model updated.
   task automatic spi_send(input logic [31:0] word, input int nbits,
                           input bit raise_cs, input bit expect_ev);
      cs = 1'b0;
      clks(HALF);
      for (int i = nbits - 1; i >= 0; i--) begin
         mosi = word[i];
         clks(HALF);
         sclk = 1'b1;
         clks(HALF);
         sclk = 1'b0;
         clks(HALF);
         dout_cap[nbits - 1 - i] = dout;
      end
      if (raise_cs) begin
         if (expect_ev) begin
            if (nbits >= 16) begin
               exp_q.push_back('{err: 1'b0, addr: word[11:8], data: word[7:0]});
               model_write(word[11:8], word[7:0]);
            end else begin
               exp_q.push_back('{err: 1'b1, addr: 4'h0, data: 8'h00});
            end
         end
         cs = 1'b1;
         clks(HALF + 4);
      end
   endtask

   // Scoreboard: every pulse must match the oldest expected frame event.
   always @(negedge clk) begin
      if (frame_valid || frame_err) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_pulse valid=%0b err=%0b addr=%h data=%h expected no pulse",
                     frame_valid, frame_err, frame_addr, frame_data);
         end else begin
            ev_t ev;
            ev = exp_q.pop_front();
            if (ev.err) begin
               if (!(frame_err === 1'b1 && frame_valid === 1'b0)) begin
                  failures++;
                  $display("FAIL frame_err_pulse got valid=%0b err=%0b expected valid=0 err=1",
                           frame_valid, frame_err);
               end
            end else if (!(frame_valid === 1'b1 && frame_err === 1'b0 &&
                           frame_addr === ev.addr && frame_data === ev.data)) begin
               failures++;
               $display("FAIL frame_valid_pulse got valid=%0b err=%0b addr=%h data=%h expected valid=1 err=0 addr=%h data=%h",
                        frame_valid, frame_err, frame_addr, frame_data, ev.addr, ev.data);
            end
         end
      end
   end

   task automatic test_reset();
      logic [30:0] got;
      model_reset();
      reset = 1'b1;
      clks(4);
      reset = 1'b0;
      clks(4);
      got = {dout, shutdown_n, decode_mode, intensity, scan_limit, display_test,
             frame_valid, frame_err, frame_addr, frame_data};
      checks++;
      if (got !== 31'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%h expected=0", got);
      end
      for (int r = 0; r < 8; r++) begin
         rd_addr = 3'(r);
         #1;
         checks++;
         if (rd_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_row%0d got=%h expected=00", r, rd_data);
         end
      end
   endtask

   task automatic test_shutdown();
      spi_send(32'h0C01, 16, 1'b1, 1'b1);
      checks++;
      if ({shutdown_n, frame_addr, frame_data} !== {exp_shdn, 4'hC, 8'h01}) begin
         failures++;
         $display("FAIL shutdown_frame got shdn=%0b addr=%h data=%h expected shdn=1 addr=c data=01",
                  shutdown_n, frame_addr, frame_data);
      end
   endtask

   task automatic test_rows();
      spi_send(32'h02FF, 16, 1'b1, 1'b1);
      spi_send(32'h0355, 16, 1'b1, 1'b1);
      spi_send(32'h08F0, 16, 1'b1, 1'b1);
      for (int r = 0; r < 8; r++) begin
         rd_addr = 3'(r);
         #1;
         checks++;
         if (rd_data !== exp_row[r]) begin
            failures++;
            $display("FAIL row%0d got=%h expected=%h", r, rd_data, exp_row[r]);
         end
      end
   endtask

   task automatic test_short_frame();
      spi_send(32'h0A, 8, 1'b1, 1'b1);
      checks++;
      if (intensity !== exp_int) begin
         failures++;
         $display("FAIL short_frame_intensity got=%h expected=%h", intensity, exp_int);
      end
   endtask

   task automatic test_long_frame();
      logic [7:0] echo;
      spi_send(32'hAB0A07, 24, 1'b1, 1'b1);
      checks++;
      if (intensity !== 4'h7) begin
         failures++;
         $display("FAIL long_frame_intensity got=%h expected=7", intensity);
      end
      for (int k = 0; k < 8; k++) echo[7 - k] = dout_cap[15 + k];
      checks++;
      if (echo !== 8'hAB) begin
         failures++;
         $display("FAIL long_frame_dout_echo got=%h expected=ab", echo);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [30:0] got;
      spi_send(32'h0B07 >> 7, 9, 1'b0, 1'b0);
      reset = 1'b1;
      model_reset();
      clks(3);
      got = {dout, shutdown_n, decode_mode, intensity, scan_limit, display_test,
             frame_valid, frame_err, frame_addr, frame_data};
      checks++;
      if (got !== 31'd0) begin
         failures++;
         $display("FAIL mid_frame_reset_outputs got=%h expected=0", got);
      end
      reset = 1'b0;
      // cs is still low: this frame must be ignored entirely.
      spi_send(32'h0B07, 16, 1'b0, 1'b0);
      cs = 1'b1;
      clks(HALF + 4);
      checks++;
      if (scan_limit !== 3'h0) begin
         failures++;
         $display("FAIL ignored_after_reset scan_limit got=%h expected=0", scan_limit);
      end
      spi_send(32'h0B05, 16, 1'b1, 1'b1);
      checks++;
      if (scan_limit !== exp_scan) begin
         failures++;
         $display("FAIL scan_limit_after_reset got=%h expected=%h", scan_limit, exp_scan);
      end
   endtask

   task automatic test_ignored_addr();
      logic [16:0] got, exp;
      spi_send(32'h0D33, 16, 1'b1, 1'b1);
      spi_send(32'h0055, 16, 1'b1, 1'b1);
      got = {shutdown_n, decode_mode, intensity, scan_limit, display_test};
      exp = {exp_shdn, exp_decode, exp_int, exp_scan, exp_test};
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL ignored_addr_regs got=%h expected=%h", got, exp);
      end
      for (int r = 0; r < 8; r++) begin
         rd_addr = 3'(r);
         #1;
         checks++;
         if (rd_data !== exp_row[r]) begin
            failures++;
            $display("FAIL ignored_addr_row%0d got=%h expected=%h", r, rd_data, exp_row[r]);
         end
      end
   endtask

   task automatic test_back_to_back();
      spi_send(32'h09A5, 16, 1'b1, 1'b1);
      spi_send(32'h0F01, 16, 1'b1, 1'b1);
      spi_send(32'h0C00, 16, 1'b1, 1'b1);
      checks++;
      if ({decode_mode, display_test, shutdown_n} !== {exp_decode, exp_test, exp_shdn}) begin
         failures++;
         $display("FAIL back_to_back got decode=%h test=%0b shdn=%0b expected decode=%h test=%0b shdn=%0b",
                  decode_mode, display_test, shutdown_n, exp_decode, exp_test, exp_shdn);
      end
   endtask

   initial begin
      test_reset();
      test_shutdown();
      test_rows();
      test_short_frame();
      test_long_frame();
      test_reset_mid_frame();
      test_ignored_addr();
      test_back_to_back();
      clks(10);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got=%0d pending expected=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
